// File: rtl/mem_responder_pkg.sv
// Shared encodings for the multicycle MIPS memory responder: access modes, FSM states, byte lanes.
// Byte order is big-endian, so lane 0 occupies bits 31:24.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MODE_WORD  = 2'b00,
    MODE_SBYTE = 2'b01,
    MODE_UBYTE = 2'b10,
    MODE_ILL   = 2'b11
  } mem_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Bit offset of a lane's least significant bit within the word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    logic [4:0] sh;
    case (lane)
      LANE0:   sh = 5'd24;
      LANE1:   sh = 5'd16;
      LANE2:   sh = 5'd8;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mem_responder_byte_lane_unit.sv
// Combinational lane extract/extend for loads and lane merge for stores; flags illegal accesses.
// Zero latency; no handshake.
module byte_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_mode_t   mode,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        bad
);

  logic [4:0]  sh;
  logic [7:0]  lane_byte;
  logic [31:0] lane_mask;

  always_comb begin
    sh         = lane_shift(lane);
    lane_byte  = 8'(word >> sh);
    lane_mask  = 32'h0000_00FF << sh;
    load_data  = 32'h0;
    store_word = (word & ~lane_mask) | ({24'h0, wdata[7:0]} << sh);
    bad        = (mode == MODE_ILL) || ((mode == MODE_WORD) && (lane != LANE0));
    case (mode)
      MODE_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      MODE_SBYTE: load_data = {{24{lane_byte[7]}}, lane_byte};
      MODE_UBYTE: load_data = {24'h0, lane_byte};
      default:    load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: response strobe 2+WAIT_CYCLES cycles after acceptance.
// ready is low while a request is in flight; requests offered then are dropped, not queued.
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        mem_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEP_U = DEPTH;

  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  mem_mode_t         mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [31:0]      load_data;
  logic [31:0]      store_word;
  logic             bad;

  // Upper address bits beyond the array simply wrap the word index.
  assign idx = IDX_W'(32'(addr_q[ADDR_W-1:2]) % DEP_U);

  byte_lane_unit u_lane (
    .word       (mem[idx]),
    .lane       (addr_q[1:0]),
    .mode       (mode_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word),
    .bad        (bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      err     <= 1'b0;
      wr_q    <= 1'b0;
      mode_q  <= MODE_WORD;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            mode_q  <= mem_mode_t'(mem_mode);
            addr_q  <= addr;
            wdata_q <= wdata;
            ready   <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          rvalid <= 1'b1;
          err    <= bad;
          rdata  <= (bad || wr_q) ? 32'h0 : load_data;
          ready  <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Array is updated only in the response cycle, so a reset earlier aborts the store.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_RESP) && wr_q && !bad) begin
      mem[idx] <= store_word;
    end
  end

endmodule
